fft_ctrl: RTL and testbench

FFT_CTRL -- requirements
Module: fft_ctrl

---
 rtl/fft_ctrl.sv | 123 ++++++++++++
 tb/tb_fft_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_ctrl.sv
// Sequencer between a streaming sample source, an FFT core and a result consumer.
// Frames are N samples in, one compute pass, N results out, with sticky error flags.
module fft_ctrl #(
    parameter int width   = 16,
    parameter int N_2     = 5,
    parameter int TIMEOUT = 84
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [width-1:0] in_data,
    output logic             in_ready,
    output logic             fft_load,
    output logic [width-1:0] fft_rd,
    output logic             fft_start,
    input  logic             fft_done,
    output logic [N_2-1:0]   out_adr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy,
    output logic             overrun,
    output logic             timeout_err
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [N_2-1:0] ONE    = N_2'(1);
    localparam logic [N_2-1:0] LAST   = '1;
    localparam logic [N_2-1:0] PENULT = LAST - ONE;
    localparam logic [CW-1:0]  TLIM   = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0]  CONE   = CW'(1);

    typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, UNLOAD} state_t;

    state_t         state;
    logic [N_2-1:0] scnt;
    logic [N_2-1:0] rcnt;
    logic [CW-1:0]  ccnt;
    logic           rx_open;
    logic           accept;

    // rx_open mirrors IDLE/LOAD; masking with reset keeps in_ready low while reset is held
    assign in_ready = rx_open & ~reset;
    assign accept   = in_valid & in_ready;
    assign fft_load = accept;
    assign fft_rd   = in_data;
    assign out_adr  = rcnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            scnt        <= '0;
            rcnt        <= '0;
            ccnt        <= '0;
            rx_open     <= 1'b1;
            fft_start   <= 1'b0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (in_valid && (state == COMPUTE || state == UNLOAD))
                overrun <= 1'b1;

            case (state)
                IDLE: begin
                    if (accept) begin
                        scnt  <= scnt + ONE;
                        state <= LOAD;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        scnt <= scnt + ONE;
                        if (scnt == LAST) begin
                            state     <= COMPUTE;
                            rx_open   <= 1'b0;
                            fft_start <= 1'b1;
                            ccnt      <= '0;
                        end
                    end
                end
                COMPUTE: begin
                    // ccnt==0 marks the first compute cycle, where a stale done is ignored
                    if (fft_done && ccnt != '0) begin
                        state     <= UNLOAD;
                        fft_start <= 1'b0;
                        out_valid <= 1'b1;
                        out_last  <= 1'b0;
                        rcnt      <= '0;
                    end else if (ccnt == TLIM) begin
                        state       <= IDLE;
                        fft_start   <= 1'b0;
                        busy        <= 1'b0;
                        rx_open     <= 1'b1;
                        timeout_err <= 1'b1;
                    end else begin
                        ccnt <= ccnt + CONE;
                    end
                end
                UNLOAD: begin
                    if (out_ready) begin
                        if (rcnt == LAST) begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            busy      <= 1'b0;
                            rx_open   <= 1'b1;
                            rcnt      <= '0;
                        end else begin
                            rcnt     <= rcnt + ONE;
                            out_last <= (rcnt == PENULT);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_ctrl.sv
// Randomized frame-level bench for fft_ctrl: a driver pushes expected loads and
// results into queues, a negedge monitor pops and compares them.
module tb_fft_ctrl;

    localparam int W       = 16;
    localparam int N_2     = 5;
    localparam int N       = 32;
    localparam int TIMEOUT = 84;

    logic           clk = 1'b0;
    logic           reset;
    logic           in_valid;
    logic [W-1:0]   in_data;
    logic           in_ready;
    logic           fft_load;
    logic [W-1:0]   fft_rd;
    logic           fft_start;
    logic           fft_done;
    logic [N_2-1:0] out_adr;
    logic           out_valid;
    logic           out_ready;
    logic           out_last;
    logic           busy;
    logic           overrun;
    logic           timeout_err;

    typedef struct packed {
        logic [N_2-1:0] adr;
        logic           last;
    } oexp_t;

    logic [W-1:0] load_q[$];
    oexp_t        out_q[$];

    int vectors    = 0;
    int miscompares = 0;
    bit exp_ovr    = 1'b0;
    bit exp_tmo    = 1'b0;

    fft_ctrl #(.width(W), .N_2(N_2), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .fft_load(fft_load), .fft_rd(fft_rd), .fft_start(fft_start),
        .fft_done(fft_done), .out_adr(out_adr), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .busy(busy),
        .overrun(overrun), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkn(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard side: every load and every result handshake must match the queues
    always @(negedge clk) begin
        if (fft_load === 1'b1) begin
            if (load_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_load: got fft_rd=%0h expected no load at %0t", fft_rd, $time);
            end else begin
                chkn("fft_rd", 32'(fft_rd), 32'(load_q.pop_front()));
            end
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (out_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_result: got adr=%0d expected no result at %0t", out_adr, $time);
            end else begin
                oexp_t e;
                e = out_q.pop_front();
                chkn("out_adr", 32'(out_adr), 32'(e.adr));
                chk1("out_last", out_last, e.last);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer samples until n have been accepted; the block is ready throughout IDLE/LOAD
    task automatic load_samples(input int n, input int vprob);
        int acc;
        int guard;
        logic [W-1:0] d;
        acc = 0;
        guard = 0;
        while (acc < n && guard < 2000) begin
            d = W'($urandom);
            in_data = d;
            in_valid = ($urandom_range(99) < vprob);
            chk1("in_ready_load", in_ready, 1'b1);
            chk1("start_during_load", fft_start, 1'b0);
            if (in_valid) begin
                load_q.push_back(d);
                acc++;
            end
            tick();
            guard++;
        end
        in_valid = 1'b0;
        chkn("accepted_samples", 32'(acc), 32'(n));
    endtask

    // done_cyc: compute cycle in which fft_done is raised (0 = never)
    task automatic run_frame(input int vprob, input int done_cyc, input bit early,
                             input bit ovr, input int stall_at, input int stall_len,
                             input bit rnd_ready);
        int c;
        bit fin;
        int r;
        int stalls;
        int held;
        int guard;
        bit rdy;

        load_samples(N, vprob);

        c = 0;
        fin = 1'b0;
        while (!fin) begin
            c++;
            chk1("fft_start_compute", fft_start, 1'b1);
            chk1("in_ready_compute", in_ready, 1'b0);
            chk1("busy_compute", busy, 1'b1);
            chk1("out_valid_compute", out_valid, 1'b0);
            if (c == TIMEOUT)
                chk1("timeout_err_before", timeout_err, exp_tmo);
            in_valid = ovr;
            in_data  = W'($urandom);
            fft_done = (early && c == 1) || (c == done_cyc);
            tick();
            if ((c == done_cyc && c > 1) || c == TIMEOUT)
                fin = 1'b1;
        end
        fft_done = 1'b0;
        if (ovr)
            exp_ovr = 1'b1;

        if (done_cyc == 0) begin
            in_valid = 1'b0;
            exp_tmo = 1'b1;
            chk1("timeout_err", timeout_err, 1'b1);
            chk1("fft_start_after_to", fft_start, 1'b0);
            chk1("busy_after_to", busy, 1'b0);
            chk1("in_ready_after_to", in_ready, 1'b1);
            chk1("out_valid_after_to", out_valid, 1'b0);
            chk1("overrun_after_to", overrun, exp_ovr);
            return;
        end

        for (int i = 0; i < N; i++)
            out_q.push_back('{N_2'(i), (i == N - 1)});

        r = 0;
        stalls = 0;
        held = 0;
        guard = 0;
        while (r < N && guard < 2000) begin
            rdy = rnd_ready ? ($urandom_range(1) == 1) : 1'b1;
            if (r == stall_at && stalls < stall_len) begin
                rdy = 1'b0;
                stalls++;
            end
            out_ready = rdy;
            in_valid  = ovr;
            chk1("out_valid_unload", out_valid, 1'b1);
            chkn("out_adr_unload", 32'(out_adr), 32'(r));
            chk1("fft_start_unload", fft_start, 1'b0);
            chk1("in_ready_unload", in_ready, 1'b0);
            if (r == stall_at)
                held++;
            tick();
            if (rdy)
                r++;
            guard++;
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chkn("results_delivered", 32'(r), 32'(N));
        if (stall_at >= 0)
            chkn("adr_hold_cycles", 32'(held), 32'(stall_len + 1));
        chk1("out_valid_after", out_valid, 1'b0);
        chk1("busy_after", busy, 1'b0);
        chk1("in_ready_after", in_ready, 1'b1);
        chk1("overrun_flag", overrun, exp_ovr);
        chk1("timeout_flag", timeout_err, exp_tmo);
        chkn("load_q_drained", 32'(load_q.size()), 32'(0));
        chkn("out_q_drained", 32'(out_q.size()), 32'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk1({tag, "_in_ready"}, in_ready, 1'b0);
        chk1({tag, "_fft_load"}, fft_load, 1'b0);
        chk1({tag, "_fft_start"}, fft_start, 1'b0);
        chk1({tag, "_out_valid"}, out_valid, 1'b0);
        chk1({tag, "_out_last"}, out_last, 1'b0);
        chk1({tag, "_busy"}, busy, 1'b0);
        chkn({tag, "_out_adr"}, 32'(out_adr), 32'(0));
        chk1({tag, "_overrun"}, overrun, 1'b0);
        chk1({tag, "_timeout_err"}, timeout_err, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b1;
        in_data   = '0;
        fft_done  = 1'b0;
        out_ready = 1'b0;
        #2;
        check_reset_outputs("por");
        tick();
        in_valid = 1'b0;
        reset    = 1'b0;
        #1;
        chk1("in_ready_after_por", in_ready, 1'b1);
        chk1("busy_after_por", busy, 1'b0);
        tick();

        // full-rate frame, done in the 20th compute cycle
        run_frame(100, 20, 1'b0, 1'b0, -1, 0, 1'b0);
        // 50% valid, consumer stalls 3 cycles at address 7
        run_frame(50, 20, 1'b0, 1'b0, 7, 3, 1'b0);
        // samples offered during compute and unload are dropped
        run_frame(100, 12, 1'b0, 1'b1, -1, 0, 1'b0);
        // done raised in the first compute cycle must be ignored
        run_frame(100, 20, 1'b1, 1'b0, -1, 0, 1'b0);
        // done on the last permitted compute cycle still completes the frame
        run_frame(100, TIMEOUT, 1'b0, 1'b0, 2, 1, 1'b0);
        // core never finishes
        run_frame(100, 0, 1'b0, 1'b0, -1, 0, 1'b0);
        run_frame(80, 5, 1'b0, 1'b0, -1, 0, 1'b1);

        // reset in the middle of loading a frame
        load_samples(17, 100);
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = W'($urandom);
        #2;
        exp_ovr = 1'b0;
        exp_tmo = 1'b0;
        check_reset_outputs("mid");
        tick();
        tick();
        check_reset_outputs("mid_hold");
        in_valid = 1'b0;
        reset    = 1'b0;
        #1;
        chk1("in_ready_after_mid", in_ready, 1'b1);
        chk1("out_valid_after_mid", out_valid, 1'b0);
        tick();
        run_frame(100, 20, 1'b0, 1'b0, -1, 0, 1'b0);

        for (int k = 0; k < 3; k++)
            run_frame(70, int'($urandom_range(TIMEOUT, 2)), 1'b0, 1'b0, -1, 0, 1'b1);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
